// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding register lets the next word be accepted while the current one shifts.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    // state     | meaning
    // ST_IDLE   | shifter empty, serial line held low
    // ST_ACTIVE | shifter driving bit r_cnt of the current word
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    logic             w_accept;
    logic             w_active;
    logic             w_at_last;
    logic             w_load_hold;
    logic             w_load_din;
    logic [WIDTH-1:0] w_shift_next;

    assign din_ready   = !reset && !r_hold_full;
    assign w_accept    = din_valid && din_ready;
    assign w_active    = (r_state == ST_ACTIVE);
    assign w_at_last   = w_active && (r_cnt == CNT_LAST);
    assign w_load_hold = w_at_last && r_hold_full;
    // A new word goes straight to the shifter when idle or when it closes the gap after a last bit.
    assign w_load_din  = w_accept && (!w_active || (w_at_last && !r_hold_full));

    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};

    assign out       = w_active && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
    assign out_valid = w_active;
    assign last      = w_at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load_hold) begin
                r_state     <= ST_ACTIVE;
                r_cnt       <= '0;
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
            end else if (w_load_din) begin
                r_state <= ST_ACTIVE;
                r_cnt   <= '0;
                r_shift <= din;
            end else if (w_at_last) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_active) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= w_shift_next;
            end

            // Hold can only be written while it is empty, so it never collides with w_load_hold.
            if (w_accept && !w_load_din) begin
                r_hold      <= din;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] din_m;
    logic         din_valid_m;
    logic         din_ready_m;
    logic         out_m;
    logic         out_valid_m;
    logic         last_m;
    logic [W-1:0] din_l;
    logic         din_valid_l;
    logic         din_ready_l;
    logic         out_l;
    logic         out_valid_l;
    logic         last_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(din_valid_m),
        .din_ready(din_ready_m), .out(out_m), .out_valid(out_valid_m), .last(last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .out(out_l), .out_valid(out_valid_l), .last(last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic l;
    } mbit_t;

    // Model: every bit still to be emitted, head = bit on the line this cycle.
    mbit_t q[$];
    logic  obs_log[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        mbit_t e;
        for (int i = 0; i < W; i++) begin
            e.b = w[W-1-i];
            e.l = (i == W - 1);
            q.push_back(e);
        end
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance one clock.
    task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
        check("out_valid", out_valid_m, q.size() > 0);
        check("out", out_m, (q.size() > 0) ? q[0].b : 1'b0);
        check("last", last_m, (q.size() > 0) ? q[0].l : 1'b0);
        check("din_ready", din_ready_m, q.size() <= W);
        if (out_valid_m === 1'b1) obs_log.push_back(out_m);
        din_m       = d;
        din_valid_m = v;
        @(posedge clk);
        acc = v && (q.size() <= W);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_word(d);
        @(negedge clk);
        din_valid_m = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cycle(1'b0, '0, a);
    endtask

    task automatic check_log(input int n, input logic [15:0] exp);
        check("log_len", obs_log.size(), n);
        for (int i = 0; i < n && i < obs_log.size(); i++)
            check("log_bit", obs_log[i], exp[n-1-i]);
    endtask

    function automatic logic [7:0] detect_1010(input logic [7:0] s);
        logic [7:0] hits;
        hits = '0;
        for (int t = 3; t < 8; t++)
            hits[t] = (s[7-t+3] == 1'b1) && (s[7-t+2] == 1'b0) &&
                      (s[7-t+1] == 1'b1) && (s[7-t] == 1'b0);
        return hits;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] stream;
        logic [3:0] lsb_word;

        reset       = 1'b1;
        din_m       = '0;
        din_valid_m = 1'b0;
        din_l       = '0;
        din_valid_l = 1'b0;
        repeat (2) @(negedge clk);
        check("out", out_m, 1'b0);
        check("out_valid", out_valid_m, 1'b0);
        check("last", last_m, 1'b0);
        check("din_ready", din_ready_m, 1'b0);
        reset = 1'b0;
        #1;
        check("din_ready_rel", din_ready_m, 1'b1);

        phase = "single";
        obs_log.delete();
        cycle(1'b1, 4'b1010, a);
        idle(6);
        check_log(4, 16'b1010);

        phase = "b2b_stall";
        obs_log.delete();
        cycle(1'b1, 4'b1010, a);
        cycle(1'b1, 4'b0110, a);
        check("second_accept", a, 1'b1);
        a = 1'b0;
        for (int k = 0; k < 10 && !a; k++) cycle(1'b1, 4'b1111, a);
        check("third_accept", a, 1'b1);
        idle(14);
        check_log(12, 16'b1010_0110_1111);

        phase = "last_load";
        obs_log.delete();
        cycle(1'b1, 4'b1010, a);
        idle(3);
        check("at_last", last_m, 1'b1);
        cycle(1'b1, 4'b1100, a);
        check("direct_accept", a, 1'b1);
        idle(6);
        check_log(8, 16'b1010_1100);

        phase = "reset_mid";
        cycle(1'b1, 4'b1010, a);
        cycle(1'b1, 4'b0110, a);
        #2 reset = 1'b1;
        #1;
        check("out", out_m, 1'b0);
        check("out_valid", out_valid_m, 1'b0);
        check("last", last_m, 1'b0);
        check("din_ready", din_ready_m, 1'b0);
        check("din_ready_lsb", din_ready_l, 1'b0);
        q.delete();
        obs_log.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("din_ready_rel", din_ready_m, 1'b1);
        cycle(1'b1, 4'b1001, a);
        idle(6);
        check_log(4, 16'b1001);

        phase = "lsb_first";
        lsb_word = 4'b0011;
        check("din_ready", din_ready_l, 1'b1);
        din_l       = lsb_word;
        din_valid_l = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid_l = 1'b0;
        din_l       = 4'b1111;
        for (int i = 0; i < W; i++) begin
            check("out", out_l, lsb_word[i]);
            check("out_valid", out_valid_l, 1'b1);
            check("last", last_l, i == W - 1);
            @(negedge clk);
        end
        check("out_valid_end", out_valid_l, 1'b0);
        check("out_end", out_l, 1'b0);

        phase = "detector";
        obs_log.delete();
        cycle(1'b1, 4'b0110, a);
        cycle(1'b1, 4'b1010, a);
        idle(10);
        check("log_len", obs_log.size(), 8);
        stream = '0;
        for (int i = 0; i < 8 && i < obs_log.size(); i++) stream[7-i] = obs_log[i];
        check("hits", detect_1010(stream), detect_1010(8'b0110_1010));

        phase = "random";
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(0, 99) < 65, W'($urandom), a);
        idle(12);
        obs_log.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
